// File: rtl/line_3_buffer_ctrl.sv
// Row scheduler for a 3-line buffer feeding a 3x3 conv stage: zero-row padding, push strobe, window handshake.
// Optional LB_CTRL_STALL_CNT_EN adds stall_cnt_o, a saturating count of back-pressured window cycles.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for start_i
// S_PAD_TOP | pushing the top zero row
// S_FILL    | accepting upstream rows until three rows are buffered
// S_WAIT_LB | letting line-buffer outputs settle for LB_LAT cycles
// S_WIN     | presenting one window to the conv engine
// S_PAD_BOT | pushing the bottom zero row
// S_DONE    | one-cycle frame completion pulse
module line_3_buffer_ctrl #(
    parameter int H      = 24,
    parameter int PAD    = 1,
    parameter int LB_LAT = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 row_valid_i,
    output logic                 row_ready_o,
    output logic                 lb_push_o,
    output logic                 lb_zero_o,
    output logic                 win_valid_o,
    input  logic                 win_ready_i,
    output logic [$clog2(H)-1:0] win_row_o,
    output logic                 busy_o,
    output logic                 frame_done_o
`ifdef LB_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt_o
`endif
);

    localparam int RW = $clog2(H);
    localparam int PW = $clog2(H + 3);
    localparam int IW = $clog2(H + 1);
    localparam int LW = (LB_LAT > 1) ? $clog2(LB_LAT) : 1;

    localparam logic [RW-1:0] LAST_ROW = RW'((PAD == 1) ? (H - 1) : (H - 3));
    localparam logic [IW-1:0] ROWS     = IW'(H);
    localparam logic [LW-1:0] LAT_LOAD = LW'(LB_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAD_TOP,
        S_FILL,
        S_WAIT_LB,
        S_WIN,
        S_PAD_BOT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_push_cnt;
    logic [IW-1:0] r_rows_in;
    logic [RW-1:0] r_win_row;
    logic [LW-1:0] r_lat_cnt;

    logic w_zero_push;

    // All outputs decode straight from the state register, so reset clears them at once.
    assign w_zero_push  = (r_state == S_PAD_TOP) || (r_state == S_PAD_BOT);
    assign row_ready_o  = (r_state == S_FILL);
    assign lb_push_o    = w_zero_push || ((r_state == S_FILL) && row_valid_i);
    assign lb_zero_o    = w_zero_push;
    assign win_valid_o  = (r_state == S_WIN);
    assign win_row_o    = r_win_row;
    assign busy_o       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign frame_done_o = (r_state == S_DONE);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state    <= S_IDLE;
            r_push_cnt <= '0;
            r_rows_in  <= '0;
            r_win_row  <= '0;
            r_lat_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i)
                        r_state <= (PAD == 1) ? S_PAD_TOP : S_FILL;
                end
                S_PAD_TOP: begin
                    r_push_cnt <= r_push_cnt + PW'(1);
                    r_state    <= S_FILL;
                end
                S_FILL: begin
                    if (row_valid_i) begin
                        r_push_cnt <= r_push_cnt + PW'(1);
                        r_rows_in  <= r_rows_in + IW'(1);
                        // Once primed, every later push completes a new window.
                        if (r_push_cnt >= PW'(2)) begin
                            r_state   <= S_WAIT_LB;
                            r_lat_cnt <= LAT_LOAD;
                        end
                    end
                end
                S_WAIT_LB: begin
                    if (r_lat_cnt == '0)
                        r_state <= S_WIN;
                    else
                        r_lat_cnt <= r_lat_cnt - LW'(1);
                end
                S_WIN: begin
                    if (win_ready_i) begin
                        r_win_row <= r_win_row + RW'(1);
                        if (r_win_row == LAST_ROW)
                            r_state <= S_DONE;
                        else if (r_rows_in < ROWS)
                            r_state <= S_FILL;
                        else
                            r_state <= S_PAD_BOT;
                    end
                end
                S_PAD_BOT: begin
                    r_push_cnt <= r_push_cnt + PW'(1);
                    r_lat_cnt  <= LAT_LOAD;
                    r_state    <= S_WAIT_LB;
                end
                S_DONE: begin
                    r_push_cnt <= '0;
                    r_rows_in  <= '0;
                    r_win_row  <= '0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LB_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn)
            r_stall_cnt <= '0;
        else if ((r_state == S_IDLE) && start_i)
            r_stall_cnt <= '0;
        else if ((r_state == S_WIN) && !win_ready_i && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_line_3_buffer_ctrl.sv
// Bench for line_3_buffer_ctrl: instance 0 uses PAD=1/LB_LAT=1, instance 1 uses PAD=0/LB_LAT=2, both H=24.
// A frame-level scoreboard checks every cycle; directed frames pin the totals with literal expectations.
module tb_line_3_buffer_ctrl;

    localparam int H = 24;
    localparam int LIMIT = 3000;

    int pad_of [2] = '{1, 0};
    int lat_of [2] = '{1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [2];
    logic       st   [2];
    logic       rv   [2];
    logic       wr   [2];
    logic       rr   [2];
    logic       push [2];
    logic       zero [2];
    logic       wv   [2];
    logic       busy [2];
    logic       done [2];
    logic [4:0] wrow [2];
`ifdef LB_CTRL_STALL_CNT_EN
    logic [15:0] scnt [2];
`endif

    line_3_buffer_ctrl #(.H(H), .PAD(1), .LB_LAT(1)) dut0 (
        .clk(clk), .resetn(rst[0]), .start_i(st[0]), .row_valid_i(rv[0]),
        .row_ready_o(rr[0]), .lb_push_o(push[0]), .lb_zero_o(zero[0]),
        .win_valid_o(wv[0]), .win_ready_i(wr[0]), .win_row_o(wrow[0]),
        .busy_o(busy[0]), .frame_done_o(done[0])
`ifdef LB_CTRL_STALL_CNT_EN
        , .stall_cnt_o(scnt[0])
`endif
    );

    line_3_buffer_ctrl #(.H(H), .PAD(0), .LB_LAT(2)) dut1 (
        .clk(clk), .resetn(rst[1]), .start_i(st[1]), .row_valid_i(rv[1]),
        .row_ready_o(rr[1]), .lb_push_o(push[1]), .lb_zero_o(zero[1]),
        .win_valid_o(wv[1]), .win_ready_i(wr[1]), .win_row_o(wrow[1]),
        .busy_o(busy[1]), .frame_done_o(done[1])
`ifdef LB_CTRL_STALL_CNT_EN
        , .stall_cnt_o(scnt[1])
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard state: what the frame has done so far, in rows and windows.
    int cyc = 0;
    int m_busy       [2] = '{0, 0};
    int m_done_exp   [2] = '{0, 0};
    int m_pushes     [2] = '{0, 0};
    int m_zpush      [2] = '{0, 0};
    int m_dpush      [2] = '{0, 0};
    int m_wins       [2] = '{0, 0};
    int m_last_push  [2] = '{0, 0};
    int m_prev_wv    [2] = '{0, 0};
    int m_stall_obs  [2] = '{0, 0};
    int m_frames     [2] = '{0, 0};
    int m_last_row   [2] = '{-1, -1};
`ifdef LB_CTRL_STALL_CNT_EN
    int m_stall      [2] = '{0, 0};
`endif

    always @(negedge clk) begin : compare
        int nwin;
        int npush;
        int ez;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            nwin  = H + 2 * pad_of[d] - 2;
            npush = H + 2 * pad_of[d];
            if (rst[d]) begin
                chk("reset_outputs",
                    int'({rr[d], push[d], zero[d], wv[d], busy[d], done[d], wrow[d]}), 0);
`ifdef LB_CTRL_STALL_CNT_EN
                chk("reset_stall_cnt", int'(scnt[d]), 0);
                m_stall[d] = 0;
`endif
                m_busy[d] = 0; m_done_exp[d] = 0; m_pushes[d] = 0; m_zpush[d] = 0;
                m_dpush[d] = 0; m_wins[d] = 0; m_prev_wv[d] = 0;
            end else begin
`ifdef LB_CTRL_STALL_CNT_EN
                chk("stall_cnt", int'(scnt[d]), m_stall[d]);
`endif
                chk("busy", int'(busy[d]), m_busy[d]);
                chk("frame_done", int'(done[d]), m_done_exp[d]);
                if (done[d]) m_frames[d]++;
                m_done_exp[d] = 0;
                chk("ready_with_window", int'(rr[d] && wv[d]), 0);
                chk("push_with_window", int'(push[d] && wv[d]), 0);
                if (rr[d])
                    chk("ready_needs_row", int'(m_busy[d] == 1 && m_dpush[d] < H
                                                && m_pushes[d] < m_wins[d] + 3), 1);
                if (push[d]) begin
                    ez = (pad_of[d] == 1 && (m_pushes[d] == 0 || m_pushes[d] == H + 1)) ? 1 : 0;
                    chk("push_zero_sel", int'(zero[d]), ez);
                    if (!zero[d]) chk("data_push_needs_hs", int'(rv[d] && rr[d]), 1);
                    chk("push_in_frame", int'(m_busy[d] == 1 && m_pushes[d] < npush), 1);
                    m_pushes[d]++;
                    if (zero[d]) m_zpush[d]++; else m_dpush[d]++;
                    m_last_push[d] = cyc;
                end else begin
                    chk("hs_without_push", int'(rv[d] && rr[d]), 0);
                    chk("zero_without_push", int'(zero[d]), 0);
                end
                if (wv[d]) begin
                    chk("win_row", int'(wrow[d]), m_wins[d]);
                    chk("win_rows_buffered", m_pushes[d], m_wins[d] + 3);
                    if (m_prev_wv[d] == 0)
                        chk("win_latency", cyc - m_last_push[d], lat_of[d] + 1);
                    if (wr[d]) begin
                        m_last_row[d] = int'(wrow[d]);
                        m_wins[d]++;
                        if (m_wins[d] == nwin) begin
                            m_busy[d]     = 0;
                            m_done_exp[d] = 1;
                        end
                    end else begin
                        m_stall_obs[d]++;
`ifdef LB_CTRL_STALL_CNT_EN
                        if (m_stall[d] < 65535) m_stall[d]++;
`endif
                    end
                end
                m_prev_wv[d] = int'(wv[d]);
                if (st[d] && m_busy[d] == 0 && !done[d]) begin
                    m_busy[d] = 1; m_pushes[d] = 0; m_zpush[d] = 0; m_dpush[d] = 0;
                    m_wins[d] = 0; m_stall_obs[d] = 0; m_frames[d] = 0; m_last_row[d] = -1;
`ifdef LB_CTRL_STALL_CNT_EN
                    m_stall[d] = 0;
`endif
                end
            end
        end
    end

    // mode: 0 plain, 1 stall window 3, 2 toggle row_valid, 3 reset at window 10, 4 extra start while busy
    task automatic run_frame(input int d, input int mode);
        int budget;
        int stall_left;
        stall_left = 5;
        budget = 0;
        @(posedge clk); #1;
        st[d] = 1'b1; rv[d] = 1'b1; wr[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
        while (budget < LIMIT) begin
            @(posedge clk); #1;
            budget++;
            if (done[d]) break;
            if (mode == 3 && wv[d] && wrow[d] == 5'd10) begin
                rst[d] = 1'b1;
                #1;
                chk("async_reset_busy", int'(busy[d]), 0);
                chk("async_reset_win_valid", int'(wv[d]), 0);
                chk("async_reset_win_row", int'(wrow[d]), 0);
                chk("async_reset_ready_push", int'({rr[d], push[d], zero[d], done[d]}), 0);
                @(posedge clk); #1;
                rst[d] = 1'b0;
                break;
            end
            rv[d] = (mode == 2) ? ~rv[d] : 1'b1;
            wr[d] = 1'b1;
            st[d] = (mode == 4 && wv[d] && wrow[d] == 5'd5) ? 1'b1 : 1'b0;
            if (mode == 1 && wv[d] && wrow[d] == 5'd3 && stall_left > 0) begin
                wr[d] = 1'b0;
                stall_left--;
            end
        end
        chk("frame_within_budget", (budget < LIMIT) ? 1 : 0, 1);
        st[d] = 1'b0; rv[d] = 1'b0; wr[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic after_frame(input int d, input int e_push, input int e_zero,
                               input int e_win, input int e_last);
        chk("total_pushes", m_pushes[d], e_push);
        chk("zero_pushes", m_zpush[d], e_zero);
        chk("total_windows", m_wins[d], e_win);
        chk("last_win_row", m_last_row[d], e_last);
        chk("frame_done_count", m_frames[d], 1);
        chk("busy_after_frame", int'(busy[d]), 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; st[d] = 1'b0; rv[d] = 1'b0; wr[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", int'(busy[0]), 0);
        chk("idle_win_row", int'(wrow[0]), 0);

        run_frame(0, 0);
        after_frame(0, 26, 2, 24, 23);

        run_frame(1, 0);
        after_frame(1, 24, 0, 22, 21);

        run_frame(0, 1);
        after_frame(0, 26, 2, 24, 23);
        chk("stall_cycles_seen", m_stall_obs[0], 5);
`ifdef LB_CTRL_STALL_CNT_EN
        chk("stall_cnt_final", int'(scnt[0]), 5);
`endif

        run_frame(0, 2);
        after_frame(0, 26, 2, 24, 23);
        run_frame(1, 2);
        after_frame(1, 24, 0, 22, 21);

        run_frame(0, 3);
        chk("busy_after_abort", int'(busy[0]), 0);
        run_frame(0, 0);
        after_frame(0, 26, 2, 24, 23);

        run_frame(0, 4);
        after_frame(0, 26, 2, 24, 23);
        repeat (10) @(posedge clk);
        #1;
        chk("no_second_frame_done", m_frames[0], 1);
        chk("still_idle", int'(busy[0]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_3_buffer_ctrl.md
Name: line_3_buffer_ctrl

Overview:
- Row scheduler for the 3-line buffer feeding a 3x3 convolution stage.
- Accepts one feature-map row per upstream handshake and drives the line-buffer push strobe.
- Inserts zero rows for top/bottom padding.
- Presents one window-valid per output row to the conv engine with valid/ready backpressure, and flags frame completion.

Parameters:
- H, 24, feature-map rows per frame (H >= 3)
- PAD, 1, rows of zero padding top and bottom (0 or 1 only)
- LB_LAT, 1, line-buffer latency in cycles from push (lb_push_o) to data stable on its outputs (1..4)

Ports:
- clk  input  1  clock, rising edge
- resetn  input  1  asynchronous reset, active-high: resetn=1 clears all state immediately
- start_i  input  1  one-cycle frame start pulse, honoured only in IDLE
- row_valid_i  input  1  upstream row available on the line-buffer data input
- row_ready_o  output  1  controller accepts the row this cycle
- lb_push_o  output  1  push strobe to line buffer valid_i
- lb_zero_o  output  1  mux select: push a zero row instead of upstream data
- win_valid_o  output  1  3-row window ready for conv engine
- win_ready_i  input  1  conv engine consumes the window
- win_row_o  output  $clog2(H)  output-row index of current window
- busy_o  output  1  high from accepted start until frame_done_o
- frame_done_o  output  1  one-cycle pulse after the last window handshake

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, PAD_TOP, FILL, WAIT_LB, WIN, PAD_BOT, DONE.
- IDLE: start_i=1 -> PAD_TOP if PAD=1, else FILL; busy_o=1 the next cycle. start_i in any other state is ignored.
- PAD_TOP: one cycle with lb_push_o=1, lb_zero_o=1; push_cnt++ -> FILL.
- FILL: row_ready_o=1. On row_valid_i && row_ready_o: lb_push_o=1 in the same cycle (combinational), push_cnt++, rows_in++.
  - push_cnt reaching >=3 after the push -> WAIT_LB.
  - Otherwise stay in FILL.
- WAIT_LB: counts LB_LAT cycles, row_ready_o=0 -> WIN.
- WIN: win_valid_o=1, held stable with win_row_o until win_ready_i=1. On the handshake, win_row_o++. Next state:
  - frame done if win_row_o was the last row (H-1 when PAD=1, H-3 when PAD=0) -> DONE
  - else rows_in<H -> FILL
  - else (rows_in=H, PAD=1) -> PAD_BOT
- PAD_BOT: one cycle lb_push_o=1, lb_zero_o=1 -> WAIT_LB.
- DONE: frame_done_o=1 for one cycle, busy_o=0, counters cleared -> IDLE.
- Totals per frame: H+2*PAD pushes, H+2*PAD-2 windows.
- row_ready_o is never asserted while win_valid_o=1: at most one pending window. lb_push_o never coincides with win_valid_o.
- Upstream row_valid_i asserted in IDLE/WAIT_LB/WIN/DONE is not consumed.
- win_ready_i outside WIN is ignored.
- resetn asserted mid-frame: immediate return to IDLE, all outputs 0. A partially filled line buffer is not flushed; the next frame overwrites it via its pushes.
- Counters saturate-safe: push_cnt width $clog2(H+3).

Optional Feature:
- Macro LB_CTRL_STALL_CNT_EN.
- When defined: extra output port stall_cnt_o (16 bits). It counts cycles with win_valid_o=1 && win_ready_i=0, saturates at 16'hFFFF, clears on resetn and on start_i acceptance.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- H=24, PAD=1, LB_LAT=1, row_valid_i and win_ready_i tied 1, start pulse -> exactly 26 lb_push_o (first and last with lb_zero_o=1), 24 win handshakes with win_row_o 0..23, one frame_done_o, busy_o low afterwards.
- PAD=0, H=24 -> 24 pushes, all lb_zero_o=0, 22 windows with win_row_o 0..21.
- win_ready_i held 0 for 5 cycles at window 3 -> win_valid_o and win_row_o=3 stable, row_ready_o=0, no push. With LB_CTRL_STALL_CNT_EN, stall_cnt_o=5.
- row_valid_i toggling 1/0 each cycle in FILL -> pushes only on valid&&ready cycles; window order and count unchanged.
- resetn pulsed during window 10 -> all outputs 0 within same cycle. A new start then produces a full correct 24-window frame.
- start_i pulsed while busy_o=1 -> ignored; frame completes with exactly one frame_done_o.
